fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data width.
REQ-002 SHALL have parameter NREAD, default 2, meaning number of ID-stage read ports.
REQ-003 SHALL have parameter NSTG, default 3, meaning tracked in-flight stages: 0=EX, 1=MEM, 2=WB.
REQ-004 SHALL have parameter AW, default 5, meaning register address width.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-007 SHALL have port id_valid  in  1  ID holds a valid instruction.
REQ-008 SHALL have port id_raddr  in  NREAD*AW  read addresses; port k at bits [k*AW +: AW].
REQ-009 SHALL have port id_ren  in  NREAD  per-port read enable.
REQ-010 SHALL have port id_rdata_rf  in  NREAD*XLEN  register-file read data.
REQ-011 SHALL have port id_waddr  in  AW  destination register of the ID instruction.
REQ-012 SHALL have port id_we  in  1  ID instruction writes id_waddr.
REQ-013 SHALL have port stg_res  in  NSTG*XLEN  result bus of each tracked stage.
REQ-014 SHALL have port stg_res_vld  in  NSTG  stage result is final; a load in EX drives 0.
REQ-015 SHALL have port ext_hold  in  1  freeze the whole pipeline (e.g. memory wait).
REQ-016 SHALL have port flush  in  1  kill the ID instruction and the EX entry (branch redirect).
REQ-017 SHALL have port fwd_rdata  out  NREAD*XLEN  forwarded operand data.
REQ-018 SHALL have port fwd_sel  out  NREAD*2  per-port source: 0=RF, 1=EX, 2=MEM, 3=WB.
REQ-019 SHALL have port stall  out  1  hold IF/ID; insert a bubble into EX.
REQ-020 SHALL have port stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-021 SHALL keep a shadow pipeline of NSTG entries {vld, waddr, we}; entry 0 = EX.
REQ-022 SHALL define port k as matching stage s when: id_ren[k], id_raddr[k]!=0, entry s is vld and we, and waddr equals id_raddr[k].
REQ-023 SHALL select, for each port, the youngest (lowest s) matching stage; with no match the port SHALL take id_rdata_rf and fwd_sel=0.
REQ-024 SHALL set fwd_rdata to stg_res[s] when the selected stage s has stg_res_vld[s]=1; fwd_rdata and fwd_sel SHALL be combinational, with zero latency.
REQ-025 SHALL assert stall when id_valid=1, flush=0, and any port's selected stage has stg_res_vld=0; an older valid match SHALL NOT clear the stall.
REQ-026 SHALL never forward for address 0; x0 reads SHALL return id_rdata_rf.
REQ-027 SHALL hold all entries unchanged while ext_hold=1, and stall_cnt SHALL NOT increment.
REQ-028 SHALL, with ext_hold=0, shift entry s into s+1 every cycle; the oldest entry retires.
REQ-029 SHALL load entry 0 with {id_valid, id_waddr, id_we} when stall=0 and flush=0, and with a bubble (vld=0) when stall=1.
REQ-030 SHALL, on flush=1 with ext_hold=0, load entry 0 with a bubble; flush SHALL take priority over stall.
REQ-031 SHALL, when flush=1 and ext_hold=1 in the same cycle, invalidate entry 0 in place.
REQ-032 SHALL increment stall_cnt by 1 in every cycle where stall=1 and ext_hold=0, saturating at 0xFFFF_FFFF.
REQ-033 SHALL support NREAD >= 1 and NSTG from 1 to 3; fwd_sel encoding SHALL stay 2 bits.

Reset
REQ-034 SHALL, while rst_n=0, clear every entry to vld=0, waddr=0, we=0, and clear stall_cnt to 0.
REQ-035 SHALL, during reset, drive stall=0, fwd_sel=0, and fwd_rdata=id_rdata_rf.
REQ-036 SHALL, when reset is asserted mid-stall, discard all in-flight entries; the first cycle after release SHALL see no match.

Verification
REQ-037 SHALL cover EX forwarding: EX entry writes x5, stg_res[0]=0x1234, vld=1; ID reads x5 on port 0 -> fwd_sel0=1, fwd_rdata0=0x1234, stall=0.
REQ-038 SHALL cover the load-use hazard: EX entry is a load to x7 with stg_res_vld[0]=0; ID reads x7 -> stall=1 for one cycle; entry 0 gets a bubble; next cycle fwd_sel=2 with MEM data; stall_cnt=1.
REQ-039 SHALL cover priority: EX and MEM both write x3 (0xA, 0xB); ID reads x3 on both ports -> both ports return 0xA, fwd_sel=1.
REQ-040 SHALL cover x0: WB entry has waddr=0, we=1; ID reads x0 -> fwd_sel=0, RF data returned.
REQ-041 SHALL cover flush over stall: a stall condition with flush=1 -> stall=0, entry 0 gets a bubble, stall_cnt unchanged.
REQ-042 SHALL cover hold and reset: ext_hold=1 for 3 cycles -> entries are frozen and stall_cnt is frozen; rst_n low mid-stall -> stall=0 and stall_cnt=0.

Source files
------------

// File: rtl/fwd_hazard_if.sv
// Bundle of ID-stage operands, in-flight stage results and the forwarding/stall
// outputs exchanged between the pipeline and fwd_hazard_unit.
interface fwd_hazard_if #(
  parameter int XLEN  = 64,
  parameter int NREAD = 2,
  parameter int NSTG  = 3,
  parameter int AW    = 5
);
  logic                  id_valid;
  logic [NREAD*AW-1:0]   id_raddr;
  logic [NREAD-1:0]      id_ren;
  logic [NREAD*XLEN-1:0] id_rdata_rf;
  logic [AW-1:0]         id_waddr;
  logic                  id_we;
  logic [NSTG*XLEN-1:0]  stg_res;
  logic [NSTG-1:0]       stg_res_vld;
  logic                  ext_hold;
  logic                  flush;
  logic [NREAD*XLEN-1:0] fwd_rdata;
  logic [NREAD*2-1:0]    fwd_sel;
  logic                  stall;
  logic [31:0]           stall_cnt;

  modport master (
    output id_valid, id_raddr, id_ren, id_rdata_rf, id_waddr, id_we,
           stg_res, stg_res_vld, ext_hold, flush,
    input  fwd_rdata, fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_raddr, id_ren, id_rdata_rf, id_waddr, id_we,
           stg_res, stg_res_vld, ext_hold, flush,
    output fwd_rdata, fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall detection: tracks destination registers
// of the EX/MEM/WB instructions and picks the youngest producer per read port.
module fwd_hazard_unit #(
  parameter int XLEN  = 64,
  parameter int NREAD = 2,
  parameter int NSTG  = 3,
  parameter int AW    = 5
) (
  input logic         clk,
  input logic         rst_n,
  fwd_hazard_if.slave bus
);

  logic [NSTG-1:0] vld_q;
  logic [NSTG-1:0] we_q;
  logic [AW-1:0]   waddr_q [NSTG];
  logic [31:0]     stall_cnt_q;
  logic [31:0]     stall_cnt_d;
  logic [NREAD-1:0] hazard;
  logic            stall;

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
    logic [AW-1:0] raddr;
    logic          hit;
    logic [1:0]    stage_idx;
    logic          res_ok;

    assign raddr = bus.id_raddr[gi*AW +: AW];

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
      hit       = 1'b0;
      stage_idx = 2'd0;
      for (int s = NSTG - 1; s >= 0; s--) begin
        if (bus.id_ren[gi] && (raddr != '0) && vld_q[s] && we_q[s] &&
            (waddr_q[s] == raddr)) begin
          hit       = 1'b1;
          stage_idx = 2'(s);
        end
      end
    end

    assign res_ok       = bus.stg_res_vld[stage_idx];
    assign hazard[gi]   = hit && !res_ok;
    assign bus.fwd_sel[gi*2 +: 2] = hit ? (stage_idx + 2'd1) : 2'd0;
    assign bus.fwd_rdata[gi*XLEN +: XLEN] = (hit && res_ok) ?
        bus.stg_res[int'(stage_idx)*XLEN +: XLEN] :
        bus.id_rdata_rf[gi*XLEN +: XLEN];
  end

  assign stall         = rst_n && bus.id_valid && !bus.flush && (|hazard);
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      we_q        <= '0;
      stall_cnt_q <= '0;
      for (int s = 0; s < NSTG; s++) begin
        waddr_q[s] <= '0;
      end
    end else if (!bus.ext_hold) begin
      for (int s = NSTG - 1; s > 0; s--) begin
        vld_q[s]   <= vld_q[s-1];
        we_q[s]    <= we_q[s-1];
        waddr_q[s] <= waddr_q[s-1];
      end
      // Flush and stall both inject a bubble into EX.
      if (bus.flush || stall) begin
        vld_q[0]   <= 1'b0;
        we_q[0]    <= 1'b0;
        waddr_q[0] <= '0;
      end else begin
        vld_q[0]   <= bus.id_valid;
        we_q[0]    <= bus.id_we;
        waddr_q[0] <= bus.id_waddr;
      end
      stall_cnt_q <= stall_cnt_d;
    end else if (bus.flush) begin
      vld_q[0] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed test of fwd_hazard_unit: forwarding priority, x0, load-use stall,
// flush, hold and reset behaviour with hand-computed expectations.
module tb_fwd_hazard_unit;
  localparam int XLEN  = 64;
  localparam int NREAD = 2;
  localparam int NSTG  = 3;
  localparam int AW    = 5;
  localparam logic [63:0] RF0 = 64'h1111_0000_0000_1111;
  localparam logic [63:0] RF1 = 64'h2222_0000_0000_2222;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  fwd_hazard_if #(.XLEN(XLEN), .NREAD(NREAD), .NSTG(NSTG), .AW(AW)) bus ();

  fwd_hazard_unit #(.XLEN(XLEN), .NREAD(NREAD), .NSTG(NSTG), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic w);
    bus.id_valid = 1'b1;
    bus.id_waddr = a;
    bus.id_we    = w;
    bus.id_ren   = '0;
    bus.flush    = 1'b0;
    bus.ext_hold = 1'b0;
    tick();
  endtask

  task automatic set_res(input logic [63:0] r0, input logic [63:0] r1,
                         input logic [63:0] r2, input logic [2:0] v);
    bus.stg_res     = {r2, r1, r0};
    bus.stg_res_vld = v;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic e0,
                    input logic [AW-1:0] a1, input logic e1);
    bus.id_raddr = {a1, a0};
    bus.id_ren   = {e1, e0};
    bus.id_valid = 1'b1;
    bus.id_we    = 1'b0;
    bus.id_waddr = '0;
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.id_valid    = 1'b0;
    bus.id_raddr    = '0;
    bus.id_ren      = '0;
    bus.id_rdata_rf = {RF1, RF0};
    bus.id_waddr    = '0;
    bus.id_we       = 1'b0;
    bus.ext_hold    = 1'b0;
    bus.flush       = 1'b0;
    set_res(64'h0, 64'h0, 64'h0, 3'b111);
    rd(5'd5, 1'b1, 5'd6, 1'b1);
    repeat (2) tick();
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_sel", 64'(bus.fwd_sel), 64'd0);
    check("rst_data0", bus.fwd_rdata[63:0], RF0);
    check("rst_cnt", 64'(bus.stall_cnt), 64'd0);
    rst_n = 1'b1;

    // EX forwarding
    push(5'd5, 1'b1);
    set_res(64'h1234, 64'h0, 64'h0, 3'b111);
    rd(5'd5, 1'b1, 5'd9, 1'b1);
    check("ex_sel0", 64'(bus.fwd_sel[1:0]), 64'd1);
    check("ex_data0", bus.fwd_rdata[63:0], 64'h1234);
    check("ex_sel1", 64'(bus.fwd_sel[3:2]), 64'd0);
    check("ex_data1", bus.fwd_rdata[127:64], RF1);
    check("ex_stall", 64'(bus.stall), 64'd0);

    // EX beats MEM; then WB-only match
    push(5'd3, 1'b1);
    push(5'd3, 1'b1);
    set_res(64'hA, 64'hB, 64'hC, 3'b111);
    rd(5'd3, 1'b1, 5'd3, 1'b1);
    check("pri_sel0", 64'(bus.fwd_sel[1:0]), 64'd1);
    check("pri_data0", bus.fwd_rdata[63:0], 64'hA);
    check("pri_sel1", 64'(bus.fwd_sel[3:2]), 64'd1);
    check("pri_data1", bus.fwd_rdata[127:64], 64'hA);
    rd(5'd5, 1'b1, 5'd0, 1'b0);
    check("wb_sel0", 64'(bus.fwd_sel[1:0]), 64'd3);
    check("wb_data0", bus.fwd_rdata[63:0], 64'hC);

    // x0 never forwarded
    push(5'd0, 1'b1);
    push(5'd12, 1'b1);
    push(5'd13, 1'b1);
    rd(5'd0, 1'b1, 5'd13, 1'b1);
    check("x0_sel0", 64'(bus.fwd_sel[1:0]), 64'd0);
    check("x0_data0", bus.fwd_rdata[63:0], RF0);
    check("x0_sel1", 64'(bus.fwd_sel[3:2]), 64'd1);
    check("x0_data1", bus.fwd_rdata[127:64], 64'hA);

    // load-use
    push(5'd7, 1'b1);
    set_res(64'h0, 64'hBEEF, 64'h0, 3'b110);
    rd(5'd7, 1'b1, 5'd0, 1'b0);
    check("lu_stall", 64'(bus.stall), 64'd1);
    check("lu_sel0", 64'(bus.fwd_sel[1:0]), 64'd1);
    tick();
    check("lu2_sel0", 64'(bus.fwd_sel[1:0]), 64'd2);
    check("lu2_data0", bus.fwd_rdata[63:0], 64'hBEEF);
    check("lu2_stall", 64'(bus.stall), 64'd0);
    check("lu2_cnt", 64'(bus.stall_cnt), 64'd1);

    // older valid match does not clear a stall
    push(5'd8, 1'b1);
    push(5'd8, 1'b1);
    set_res(64'h0, 64'h88, 64'h0, 3'b110);
    rd(5'd8, 1'b1, 5'd0, 1'b0);
    check("old_stall", 64'(bus.stall), 64'd1);
    tick();
    check("old2_sel0", 64'(bus.fwd_sel[1:0]), 64'd2);
    check("old2_cnt", 64'(bus.stall_cnt), 64'd2);

    // flush beats stall; the flushed ID writer must not enter EX
    push(5'd9, 1'b1);
    set_res(64'h0, 64'h99, 64'h0, 3'b110);
    rd(5'd9, 1'b1, 5'd0, 1'b0);
    bus.id_we    = 1'b1;
    bus.id_waddr = 5'd9;
    bus.flush    = 1'b1;
    #1;
    check("fl_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.flush = 1'b0;
    bus.id_we = 1'b0;
    bus.id_waddr = '0;
    set_res(64'h0, 64'h99, 64'h0, 3'b111);
    #1;
    check("fl_sel0", 64'(bus.fwd_sel[1:0]), 64'd2);
    check("fl_data0", bus.fwd_rdata[63:0], 64'h99);
    check("fl_cnt", 64'(bus.stall_cnt), 64'd2);

    // hold freezes entries and counter; flush during hold kills EX in place
    push(5'd10, 1'b1);
    set_res(64'h0, 64'h0, 64'h0, 3'b110);
    rd(5'd10, 1'b1, 5'd0, 1'b0);
    bus.ext_hold = 1'b1;
    #1;
    check("hd_stall", 64'(bus.stall), 64'd1);
    repeat (3) tick();
    check("hd_sel0", 64'(bus.fwd_sel[1:0]), 64'd1);
    check("hd_cnt", 64'(bus.stall_cnt), 64'd2);
    bus.flush = 1'b1;
    #1;
    check("hdfl_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.flush    = 1'b0;
    bus.ext_hold = 1'b0;
    #1;
    check("hdfl_sel0", 64'(bus.fwd_sel[1:0]), 64'd0);
    check("hdfl_data0", bus.fwd_rdata[63:0], RF0);
    check("hdfl_stall2", 64'(bus.stall), 64'd0);
    check("hdfl_cnt", 64'(bus.stall_cnt), 64'd2);

    // reset mid-stall
    push(5'd14, 1'b1);
    rd(5'd14, 1'b1, 5'd0, 1'b0);
    check("rs_stall", 64'(bus.stall), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rs_stall0", 64'(bus.stall), 64'd0);
    check("rs_cnt", 64'(bus.stall_cnt), 64'd0);
    check("rs_sel0", 64'(bus.fwd_sel[1:0]), 64'd0);
    check("rs_data0", bus.fwd_rdata[63:0], RF0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_sel0", 64'(bus.fwd_sel[1:0]), 64'd0);
    check("rel_stall", 64'(bus.stall), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
